// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the I-fetch and D-side requesters.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_readyM,
  output logic                 err,
  output logic                 busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_i, grant_d, finish_ok, finish_to;
  logic             pick_d, in_busy, timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;  // 1 when the most recent grant went to the D side

  always_ff @(posedge clk) begin
    if (reset)                 last_grant_d <= 1'b0;
    else if (grant_i || grant_d) last_grant_d <= grant_d;
  end

  assign pick_d = d_req && (!i_req || !last_grant_d);
`else
  assign pick_d = d_req;
`endif

  assign in_busy     = (state == BUSY_I) || (state == BUSY_D);
  assign timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // A memory response on the last allowed wait cycle still counts as success.
        if ((m_readM || m_writeM) && m_readyM) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          finish_to  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes, address and write data are registered: they appear the cycle after the grant
  // and stay frozen until completion, whatever the requesters do meanwhile.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;

      if (grant_i) begin
        m_address <= i_addr;
        m_readM   <= 1'b1;
        m_writeM  <= 1'b0;
        wait_cnt  <= '0;
      end else if (grant_d) begin
        m_address <= d_addr;
        m_wdata   <= d_wdata;
        m_readM   <= ~d_we;
        m_writeM  <= d_we;
        wait_cnt  <= '0;
      end else if (in_busy && !m_readyM && (int'(wait_cnt) < TIMEOUT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (finish_ok || finish_to) begin
        m_readM  <= 1'b0;
        m_writeM <= 1'b0;
        i_ready  <= (state == BUSY_I);
        d_ready  <= (state == BUSY_D);
        err      <= finish_to;
      end

      // Read data is captured only on a real completion; writes and timeouts leave it alone.
      if (finish_ok && state == BUSY_I)            i_rdata <= m_rdata;
      if (finish_ok && state == BUSY_D && m_readM) d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked every cycle against a
// transaction-timeline model of the arbiter.
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req, d_req, d_we;
  logic [W-1:0] i_addr, d_addr, d_wdata;
  logic [W-1:0] i_rdata, d_rdata, m_address, m_wdata, m_rdata;
  logic         i_ready, d_ready, m_readM, m_writeM, m_readyM, err, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_readyM(m_readyM), .err(err), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one transaction as a timeline ----------------
  // A grant at edge g gives strobes in cycles g+1..g+win, the ready pulse in cycle
  // g+win+1, and the arbiter is idle again in the cycle after that.
  typedef struct {
    bit           owner_d;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           win;
    bit           to;
  } txn_t;

  txn_t         cur;
  bit           active = 1'b0;
  int           age = 0;          // cycles since the grant edge
  int           cur_lat = 1;      // memory answers on this strobe cycle (may exceed TO)
  bit           last_d = 1'b0;
  bit           mdl_pick_d;
  logic [W-1:0] exp_i_rdata, exp_d_rdata;

  int           forced_lat = 0;
  bit           force_data = 1'b0;
  logic [W-1:0] forced_data = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      active      = 1'b0;
      age         = 0;
      last_d      = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
    end else if (active) begin
      if (age == cur.win && !cur.to) begin
        if (!cur.owner_d)  exp_i_rdata = m_rdata;
        else if (!cur.we)  exp_d_rdata = m_rdata;
      end
      if (age == cur.win + 1) active = 1'b0;
      else                    age++;
    end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      mdl_pick_d = d_req && (!i_req || !last_d);
`else
      mdl_pick_d = d_req;
`endif
      cur_lat     = (forced_lat != 0) ? forced_lat : int'($urandom_range(1, TO + 2));
      cur.owner_d = mdl_pick_d;
      cur.we      = mdl_pick_d ? d_we : 1'b0;
      cur.addr    = mdl_pick_d ? d_addr : i_addr;
      cur.wdata   = d_wdata;
      cur.to      = (cur_lat > TO);
      cur.win     = cur.to ? TO : cur_lat;
      last_d      = mdl_pick_d;
      active      = 1'b1;
      age         = 1;
    end
  end

  // ---------------- memory responder ----------------
  int strobe_n = 0;
  always @(negedge clk) begin
    if (m_readM === 1'b1 || m_writeM === 1'b1) strobe_n++;
    else                                       strobe_n = 0;
    m_rdata = W'($urandom);
    if (strobe_n != 0 && strobe_n == cur_lat) begin
      m_readyM = 1'b1;
      if (force_data) m_rdata = forced_data;
    end else begin
      // Stray completions outside a transaction must be ignored by the arbiter.
      m_readyM = (strobe_n == 0) && ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_strobe, exp_rdy;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_strobe = active && (age <= cur.win);
      exp_rdy    = active && (age == cur.win + 1);
      check("busy",     32'(busy),     32'(active));
      check("m_readM",  32'(m_readM),  32'(exp_strobe && !cur.we));
      check("m_writeM", 32'(m_writeM), 32'(exp_strobe && cur.we));
      if (exp_strobe)           check("m_address", 32'(m_address), 32'(cur.addr));
      if (exp_strobe && cur.we) check("m_wdata",   32'(m_wdata),   32'(cur.wdata));
      check("i_ready", 32'(i_ready), 32'(exp_rdy && !cur.owner_d));
      check("d_ready", 32'(d_ready), 32'(exp_rdy && cur.owner_d));
      check("err",     32'(err),     32'(exp_rdy && cur.to));
      check("i_rdata", 32'(i_rdata), 32'(exp_i_rdata));
      check("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ready(input string tag, input bit side_d, input logic [W-1:0] exp_addr,
                            input logic [W-1:0] exp_wdata, input bit wiggle,
                            output int n_strobe, output bit err_seen);
    bit got, other;
    got = 1'b0; other = 1'b0; n_strobe = 0; err_seen = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (m_readM || m_writeM) begin
        n_strobe++;
        check({tag, "_addr"}, 32'(m_address), 32'(exp_addr));
        if (m_writeM) check({tag, "_wdata"}, 32'(m_wdata), 32'(exp_wdata));
        if (wiggle) begin
          d_addr  = ~exp_addr;
          d_wdata = ~exp_wdata;
          d_we    = ~d_we;
        end
      end
      if (side_d ? i_ready : d_ready) other = 1'b1;
      if (side_d ? d_ready : i_ready) begin
        got      = 1'b1;
        err_seen = err;
        if (side_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
    end
    check({tag, "_done"},        32'(got),   32'd1);
    check({tag, "_other_ready"}, 32'(other), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int n;
  bit e;

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forced_lat = 3; force_data = 1'b1; forced_data = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_readM",   32'(m_readM),   32'd0);
    check("rst_writeM",  32'(m_writeM),  32'd0);
    check("rst_iready",  32'(i_ready),   32'd0);
    check("rst_dready",  32'(d_ready),   32'd0);
    check("rst_err",     32'(err),       32'd0);
    check("rst_address", 32'(m_address), 32'd0);
    check("rst_irdata",  32'(i_rdata),   32'd0);
    check("rst_drdata",  32'(d_rdata),   32'd0);
    reset = 1'b0;

    // I read alone, memory answers on the third strobe cycle.
    i_req = 1'b1; i_addr = 16'h0040;
    wait_ready("ird", 1'b0, 16'h0040, 16'h0000, 1'b0, n, e);
    check("ird_strobes", 32'(n), 32'd3);
    check("ird_err",     32'(e), 32'd0);
    check("ird_data",    32'(i_rdata), 32'h0000BEEF);

    // Timeout: memory never answers; i_rdata must keep the old value.
    forced_lat = TO + 3;
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0080;
    wait_ready("ito", 1'b0, 16'h0080, 16'h0000, 1'b0, n, e);
    check("ito_strobes", 32'(n), 32'd4);
    check("ito_err",     32'(e), 32'd1);
    check("ito_data",    32'(i_rdata), 32'h0000BEEF);

    // D write with inputs changing during the transaction.
    forced_lat = 2;
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'h5A5A;
    wait_ready("dwr", 1'b1, 16'h1234, 16'h5A5A, 1'b1, n, e);
    check("dwr_strobes", 32'(n), 32'd2);
    check("dwr_rdata",   32'(d_rdata), 32'd0);

    // D read with the shortest latency.
    forced_lat = 1; forced_data = 16'hC0DE;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2222;
    wait_ready("drd", 1'b1, 16'h2222, 16'h0000, 1'b0, n, e);
    check("drd_strobes", 32'(n), 32'd1);
    check("drd_data",    32'(d_rdata), 32'h0000C0DE);

    // Memory answers on the last allowed cycle: success, not timeout.
    forced_lat = TO;
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h3333; d_wdata = 16'h0F0F;
    wait_ready("dlast", 1'b1, 16'h3333, 16'h0F0F, 1'b0, n, e);
    check("dlast_strobes", 32'(n), 32'd4);
    check("dlast_err",     32'(e), 32'd0);
    check("dlast_data",    32'(d_rdata), 32'h0000C0DE);

    // Simultaneous requests straight after reset: D first, then I.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    forced_lat = 2;
    i_req = 1'b1; i_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    wait_ready("pair_d", 1'b1, 16'h0200, 16'h0000, 1'b0, n, e);
    wait_ready("pair_i", 1'b0, 16'h0100, 16'h0000, 1'b0, n, e);

    // Reset in the middle of an I read, then the held request completes afresh.
    forced_lat = TO + 3;
    @(negedge clk); i_req = 1'b1; i_addr = 16'h0300;
    repeat (2) @(negedge clk);
    check("mid_strobe", 32'(m_readM), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_readM",  32'(m_readM), 32'd0);
    check("mid_rst_busy",   32'(busy),    32'd0);
    check("mid_rst_iready", 32'(i_ready), 32'd0);
    reset = 1'b0; forced_lat = 2; forced_data = 16'h1357;
    wait_ready("post_rst", 1'b0, 16'h0300, 16'h0000, 1'b0, n, e);
    check("post_rst_data", 32'(i_rdata), 32'h00001357);

    // Randomized traffic, occasional resets, random latencies including timeouts.
    forced_lat = 0; force_data = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if (!i_req || i_ready) i_req = ($urandom_range(0, 2) == 0);
      if (!d_req || d_ready) d_req = ($urandom_range(0, 2) == 0);
      i_addr  = W'($urandom);
      d_addr  = W'($urandom);
      d_wdata = W'($urandom);
      d_we    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
